result_serializer: RTL and testbench

//   Sits between the 3x3 matrix Calculator and uart_tx. Captures the
//   144-bit product (nine 16-bit elements R00..R22) when the multiply

---
 rtl/result_serializer.sv | 128 ++++++++++++
 tb/tb_result_serializer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/result_serializer.sv
// rtl/result_serializer.sv - captures the matrix product and streams it byte-wise to uart_tx
// Element R00 goes first and each element is sent MSB byte first; all outputs are registered.
module result_serializer #(
  parameter int N_ELEM       = 9,
  parameter int ELEM_W       = 16,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_ELEM*ELEM_W-1:0] result,
  input  logic                     result_valid,
  input  logic                     tx_busy,
  output logic [7:0]               tx_data,
  output logic                     tx_start,
  output logic                     busy,
  output logic                     done
);

  localparam int TOT_W = N_ELEM * ELEM_W;
  localparam int B     = TOT_W / 8;
  localparam int BPE   = ELEM_W / 8;
  localparam int CNT_W = $clog2(B);
  localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(B - 1);
  localparam logic [TMO_W-1:0] TMO_LIM   = TMO_W'(BUSY_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_HI,
    S_WAIT_LO,
    S_DONE
  } state_t;

  state_t             state, state_n;
  logic [TOT_W-1:0]   snap, snap_n;
  logic [CNT_W-1:0]   byte_cnt, byte_cnt_n;
  logic [TMO_W-1:0]   tmo, tmo_n, tmo_inc;
  logic [7:0]         tx_data_n;
  logic               tx_start_n, busy_n, done_n;
  logic [B*8-1:0]     stream;
  logic [7:0]         cur_byte;

  // Reorder the snapshot into transmit order: stream byte 0 is R00's MSB byte.
  for (genvar g = 0; g < B; g++) begin : g_bytes
    assign stream[g*8 +: 8] = snap[(g / BPE) * ELEM_W + (BPE - 1 - (g % BPE)) * 8 +: 8];
  end

  assign cur_byte = stream[{byte_cnt, 3'b000} +: 8];
  assign tmo_inc  = tmo + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      snap     <= '0;
      byte_cnt <= '0;
      tmo      <= '0;
      tx_data  <= '0;
      tx_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      snap     <= snap_n;
      byte_cnt <= byte_cnt_n;
      tmo      <= tmo_n;
      tx_data  <= tx_data_n;
      tx_start <= tx_start_n;
      busy     <= busy_n;
      done     <= done_n;
    end
  end

  always_comb begin
    state_n    = state;
    snap_n     = snap;
    byte_cnt_n = byte_cnt;
    tmo_n      = tmo;
    tx_data_n  = tx_data;
    tx_start_n = 1'b0;
    busy_n     = busy;
    done_n     = 1'b0;
    case (state)
      S_IDLE: begin
        if (result_valid) begin
          snap_n     = result;
          byte_cnt_n = '0;
          busy_n     = 1'b1;
          state_n    = S_SEND;
        end
      end
      S_SEND: begin
        // A transmitter still busy from earlier traffic simply delays the load.
        if (!tx_busy) begin
          tx_data_n  = cur_byte;
          tx_start_n = 1'b1;
          tmo_n      = '0;
          state_n    = S_WAIT_HI;
        end
      end
      S_WAIT_HI: begin
        if (tx_busy) begin
          state_n = S_WAIT_LO;
        end else begin
          tmo_n = tmo_inc;
          if (tmo_inc == TMO_LIM) state_n = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!tx_busy) begin
          if (byte_cnt == LAST_BYTE) begin
            state_n = S_DONE;
          end else begin
            byte_cnt_n = byte_cnt + 1'b1;
            state_n    = S_SEND;
          end
        end
      end
      S_DONE: begin
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_serializer.sv
// tb/tb_result_serializer.sv - directed bench for result_serializer with a uart_tx busy model
module tb_result_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic [143:0] result;
  logic         result_valid;
  logic         tx_busy;
  logic [7:0]   tx_data;
  logic         tx_start;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  int   busy_len  = 10;
  bit   hold_busy = 1'b0;
  int   bcnt      = 0;
  logic [7:0] bytes_q[$];
  int   start_cyc[$];
  int   done_cnt  = 0;
  int   unstable  = 0;
  int   cyc       = 0;
  bit   prev_start = 1'b0;
  logic [143:0] pat;

  always #5 clk = ~clk;

  result_serializer dut (
    .clk          (clk),
    .rst          (rst),
    .result       (result),
    .result_valid (result_valid),
    .tx_busy      (tx_busy),
    .tx_data      (tx_data),
    .tx_start     (tx_start),
    .busy         (busy),
    .done         (done)
  );

  // uart_tx model and output logger, both updated on the falling edge
  initial begin : model_mon
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start && busy_len > 0) bcnt = busy_len;
      else if (bcnt > 0) bcnt--;
      tx_busy = hold_busy || (bcnt > 0);
      if (prev_start && bytes_q.size() > 0 && tx_data !== bytes_q[$]) unstable++;
      prev_start = tx_start;
      if (tx_start === 1'b1) begin
        bytes_q.push_back(tx_data);
        start_cyc.push_back(cyc);
      end
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic clear_log();
    bytes_q.delete();
    start_cyc.delete();
    done_cnt = 0;
    unstable = 0;
  endtask

  task automatic pulse(input logic [143:0] v);
    @(negedge clk);
    result       = v;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_bytes(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (bytes_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic int count_bad_pat();
    int bad = 0;
    for (int b = 0; b < bytes_q.size(); b++)
      if (bytes_q[b] !== 8'(b + 1)) bad++;
    return bad;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    result = '0;
    result_valid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: got %b want 0", tx_start); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_basic();
    bit ok;
    int bad;
    clear_log();
    busy_len = 10;
    @(negedge clk);
    result = pat;
    result_valid = 1'b1;
    @(negedge clk);
    result_valid = 1'b0;
    #1;
    checks++; if (busy !== 1'b1 || tx_start !== 1'b0) begin errors++; $display("FAIL basic_capture: busy=%b tx_start=%b want 1 0", busy, tx_start); end
    @(negedge clk);
    #1;
    checks++; if (tx_start !== 1'b1 || tx_data !== 8'h01) begin errors++; $display("FAIL basic_latency: tx_start=%b tx_data=%h want 1 01", tx_start, tx_data); end
    wait_done(600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout: got no done want done"); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_end: got %b want 0", busy); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (bytes_q.size() != 18) begin errors++; $display("FAIL basic_count: got %0d want 18", bytes_q.size()); end
    bad = count_bad_pat();
    checks++; if (bad != 0) begin errors++; $display("FAIL basic_bytes: got %0d wrong want 0", bad); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL basic_stable: got %0d unstable want 0", unstable); end
  endtask

  task automatic test_busy_hold();
    bit ok;
    clear_log();
    busy_len = 10;
    hold_busy = 1'b1;
    repeat (2) @(negedge clk);
    pulse(pat);
    repeat (20) @(negedge clk);
    #1;
    checks++; if (bytes_q.size() != 0) begin errors++; $display("FAIL hold_no_start: got %0d starts want 0", bytes_q.size()); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy: got %b want 1", busy); end
    hold_busy = 1'b0;
    wait_done(600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_done_timeout: got no done want done"); end
    checks++; if (bytes_q.size() != 18 || bytes_q[0] !== 8'h01) begin errors++; $display("FAIL hold_first: count=%0d want 18 with first byte 01", bytes_q.size()); end
    checks++; if (count_bad_pat() != 0) begin errors++; $display("FAIL hold_bytes: got %0d wrong want 0", count_bad_pat()); end
  endtask

  task automatic test_timeout();
    bit ok;
    clear_log();
    busy_len = 0;
    pulse(pat);
    wait_done(600, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_done_timeout: got no done want done"); end
    checks++; if (bytes_q.size() != 18) begin errors++; $display("FAIL tmo_count: got %0d want 18", bytes_q.size()); end
    checks++; if (count_bad_pat() != 0) begin errors++; $display("FAIL tmo_bytes: got %0d wrong want 0", count_bad_pat()); end
    if (start_cyc.size() >= 2) begin
      checks++; if (start_cyc[1] - start_cyc[0] != 17) begin errors++; $display("FAIL tmo_gap: got %0d want 17", start_cyc[1] - start_cyc[0]); end
    end else begin
      checks++; errors++; $display("FAIL tmo_gap: got %0d starts want at least 2", start_cyc.size());
    end
    busy_len = 10;
  endtask

  task automatic test_ignore_second();
    bit ok;
    clear_log();
    busy_len = 10;
    pulse(pat);
    wait_bytes(4, 300, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_progress: got %0d bytes want 4", bytes_q.size()); end
    pulse({144{1'b1}});
    wait_done(600, ok);
    repeat (5) @(negedge clk);
    #1;
    checks++; if (bytes_q.size() != 18 || count_bad_pat() != 0) begin errors++; $display("FAIL ign_bytes: count=%0d wrong=%0d want 18 and 0", bytes_q.size(), count_bad_pat()); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clear_log();
    busy_len = 10;
    pulse(pat);
    wait_bytes(5, 300, ok);
    rst = 1'b0;
    #1;
    checks++; if (tx_start !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_outputs: tx_start=%b busy=%b done=%b want 0 0 0", tx_start, busy, done); end
    repeat (30) @(negedge clk);
    #1;
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL rstmid_no_done: got %0d want 0", done_cnt); end
    checks++; if (bytes_q.size() != 5) begin errors++; $display("FAIL rstmid_stop: got %0d bytes want 5", bytes_q.size()); end
    rst = 1'b1;
    clear_log();
    pulse(pat);
    wait_done(600, ok);
    checks++; if (!ok || bytes_q.size() != 18) begin errors++; $display("FAIL rstmid_restart: count=%0d want 18", bytes_q.size()); end
    checks++; if (bytes_q.size() == 0 || bytes_q[0] !== 8'h01) begin errors++; $display("FAIL rstmid_first: got %h want 01", bytes_q.size() ? bytes_q[0] : 8'hxx); end
  endtask

  task automatic test_zero();
    bit ok;
    int bad = 0;
    clear_log();
    busy_len = 3;
    pulse('0);
    wait_done(600, ok);
    for (int b = 0; b < bytes_q.size(); b++)
      if (bytes_q[b] !== 8'h00) bad++;
    checks++; if (!ok || bytes_q.size() != 18) begin errors++; $display("FAIL zero_count: got %0d want 18", bytes_q.size()); end
    checks++; if (bad != 0) begin errors++; $display("FAIL zero_bytes: got %0d nonzero want 0", bad); end
    checks++; if (unstable != 0) begin errors++; $display("FAIL zero_stable: got %0d unstable want 0", unstable); end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) pat[i*16 +: 16] = {8'(2*i + 1), 8'(2*i + 2)};
    test_reset();
    test_basic();
    test_busy_hold();
    test_timeout();
    test_ignore_second();
    test_reset_mid();
    test_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
